n64_controller_link: RTL

Single-wire N64 controller protocol engine. It sits between the APB control register block, which supplies polling_enable and controller_reset, and the open-drain controller data pin. It issues the 0xFF reset command or periodic 0x01 poll commands, decodes the 32-bit button response, and presents the last good word as button_data for APB readback.

---
 rtl/n64_controller_link.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/n64_controller_link.sv
// n64_controller_link: single-wire N64 controller engine (0xFF reset / 0x01 poll).
// Define N64_ERR_COUNT_EN to build the saturating receive-timeout counter.
module n64_controller_link #(
  parameter int US_CYCLES     = 100,
  parameter int POLL_GAP_US   = 1000,
  parameter int RX_TIMEOUT_US = 64
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        polling_enable,
  input  logic        controller_reset,
  input  logic        n64_data_in,
  output logic        n64_data_oe,
  output logic [31:0] button_data,
  output logic        data_valid,
  output logic        busy,
  output logic        timeout_err,
  output logic [7:0]  err_count
);
  localparam int TW   = $clog2(US_CYCLES);
  localparam int UMAX = (POLL_GAP_US > RX_TIMEOUT_US) ?
                        POLL_GAP_US : RX_TIMEOUT_US;
  localparam int UW0  = $clog2(UMAX + 1);
  localparam int UW   = (UW0 < 3) ? 3 : UW0;

  localparam logic [TW-1:0] TICK_LAST = TW'(US_CYCLES - 1);
  localparam logic [UW-1:0] US0       = '0;
  localparam logic [UW-1:0] US1       = UW'(1);
  localparam logic [UW-1:0] US2       = UW'(2);
  localparam logic [UW-1:0] US3       = UW'(3);
  localparam logic [UW-1:0] GAP_LAST  = UW'(POLL_GAP_US - 1);
  localparam logic [UW-1:0] TO_LAST   = UW'(RX_TIMEOUT_US - 1);

  typedef enum logic [2:0] {
    IDLE, TX_BIT, TX_STOP, RX_WAIT, RX_BIT, GAP
  } state_t;

  state_t        state;
  logic [TW-1:0] tick;
  logic [UW-1:0] us;
  logic [7:0]    cmd;
  logic [2:0]    bit_idx;
  logic [4:0]    bit_cnt;
  logic [30:0]   shift;
  logic          rst_sent;
  logic [1:0]    sync_q;
  logic          din;
  logic          din_d;
  logic          fall;
  logic          tick_last;
  logic          rx_to;
  logic [31:0]   shift_nxt;

  assign din       = sync_q[1];
  assign fall      = din_d & ~din;
  assign tick_last = (tick == TICK_LAST);
  assign rx_to     = (state == RX_WAIT) && !fall &&
                     tick_last && (us == TO_LAST);
  assign shift_nxt = {shift, din};
  assign busy      = (state != IDLE);

  // Sync flops idle high so reset release never looks like a falling edge
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      sync_q <= 2'b11;
      din_d  <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], n64_data_in};
      din_d  <= din;
    end
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      state       <= IDLE;
      tick        <= '0;
      us          <= '0;
      cmd         <= '0;
      bit_idx     <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      rst_sent    <= 1'b0;
      n64_data_oe <= 1'b0;
      button_data <= '0;
      data_valid  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (!controller_reset) rst_sent <= 1'b0;
      tick <= tick_last ? '0 : tick + 1'b1;
      if (tick_last) us <= us + 1'b1;
      unique case (state)
        IDLE: begin
          tick    <= '0;
          us      <= '0;
          bit_idx <= 3'd7;
          if (controller_reset && !rst_sent) begin
            cmd         <= 8'hFF;
            rst_sent    <= 1'b1;
            n64_data_oe <= 1'b1;
            state       <= TX_BIT;
          end else if (polling_enable) begin
            cmd         <= 8'h01;
            n64_data_oe <= 1'b1;
            state       <= TX_BIT;
          end
        end
        TX_BIT: begin
          if (tick_last) begin
            if (us == US3) begin
              us          <= US0;
              n64_data_oe <= 1'b1;
              if (bit_idx == 3'd0) state <= TX_STOP;
              else bit_idx <= bit_idx - 1'b1;
            end else if (us == (cmd[bit_idx] ? US0 : US2)) begin
              n64_data_oe <= 1'b0;
            end
          end
        end
        TX_STOP: begin
          if (tick_last) begin
            us          <= US0;
            bit_cnt     <= '0;
            n64_data_oe <= 1'b0;
            state       <= (cmd == 8'h01) ? RX_WAIT : GAP;
          end
        end
        RX_WAIT: begin
          if (fall) begin
            tick  <= '0;
            us    <= US0;
            state <= RX_BIT;
          end else if (rx_to) begin
            us          <= US0;
            timeout_err <= 1'b1;
            state       <= GAP;
          end
        end
        RX_BIT: begin
          if (tick_last && us == US1) begin
            us      <= US0;
            shift   <= shift_nxt[30:0];
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 5'd31) begin
              button_data <= shift_nxt;
              data_valid  <= 1'b1;
              timeout_err <= 1'b0;
              state       <= GAP;
            end else begin
              state <= RX_WAIT;
            end
          end
        end
        GAP: begin
          if (tick_last && us == GAP_LAST) begin
            us    <= US0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef N64_ERR_COUNT_EN
  logic [7:0] err_q;

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) err_q <= '0;
    else if (rx_to && err_q != 8'hFF) err_q <= err_q + 1'b1;
  end

  assign err_count = err_q;
`else
  assign err_count = 8'h00;
`endif

endmodule
